// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient bank controller:
// controller state encoding, tap/width defaults and CRC-16-CCITT constants.
package fir_ctrl_pkg;

    localparam int FIR_N_TAPS       = 211;
    localparam int FIR_COEF_WIDTH   = 16;
    localparam int FIR_ADDR_WIDTH   = 8;
    localparam int FIR_SWAP_TIMEOUT = 1024;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_CHECK     = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/fir_coef_crc16.sv
// CRC-16-CCITT accumulator (poly 0x1021, init 0xFFFF, MSB first) that folds
// one COEF_WIDTH coefficient beat per enable. Only built when FIR_COEF_CRC_EN
// is defined; the controller has no CRC logic otherwise.
`ifdef FIR_COEF_CRC_EN
module fir_coef_crc16
    import fir_ctrl_pkg::*;
#(
    parameter int COEF_WIDTH = FIR_COEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [COEF_WIDTH-1:0] data,
    output logic [15:0]           crc
);

    logic [15:0] crc_next;

    // Fold the whole beat into the running CRC, most significant bit first
    always_comb begin
        crc_next = crc;
        for (int i = COEF_WIDTH - 1; i >= 0; i--) begin
            if (crc_next[15] ^ data[i]) begin
                crc_next = {crc_next[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                crc_next = {crc_next[14:0], 1'b0};
            end
        end
    end

    // CRC register: restarts at the seed for each new load, advances per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (enable) begin
            crc <= crc_next;
        end
    end

endmodule
`endif

// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered coefficient controller for the FIR datapath.
// A config master streams a full coefficient set into the shadow bank; the
// banks are then swapped on a sample-free cycle (or forced after a timeout),
// and mix_window flags the outputs that still span old and new taps.
// Optional feature macro: FIR_COEF_CRC_EN adds a one-cycle CRC check of the
// loaded set before the swap is allowed.
module fir_coef_bank_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int N            = FIR_N_TAPS,
    parameter int COEF_WIDTH   = FIR_COEF_WIDTH,
    parameter int ADDR_WIDTH   = FIR_ADDR_WIDTH,
    parameter int SWAP_TIMEOUT = FIR_SWAP_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic                  cfg_valid,
    input  logic [COEF_WIDTH-1:0] cfg_data,
    input  logic [15:0]           cfg_crc,
    output logic                  cfg_ready,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_error,
    input  logic                  sample_valid,
    output logic                  bank_wr_en,
    output logic                  bank_wr_sel,
    output logic [ADDR_WIDTH-1:0] bank_wr_addr,
    output logic [COEF_WIDTH-1:0] bank_wr_data,
    output logic                  active_bank,
    output logic                  mix_window
);

    localparam int                    WAIT_WIDTH = $clog2(SWAP_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N - 1);
    // wait_cnt holds the number of completed WAIT_SWAP cycles, so the swap is
    // forced on the edge that closes the SWAP_TIMEOUT-th waiting cycle
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST  = WAIT_WIDTH'(SWAP_TIMEOUT - 1);

    ctrl_state_t           state;
    ctrl_state_t           state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic [ADDR_WIDTH-1:0] mix_cnt;
    logic                  accept;
    logic                  do_swap;
    logic                  do_abort;
    logic                  load_fail;

`ifdef FIR_COEF_CRC_EN
    logic        crc_clear;
    logic [15:0] crc_value;

    assign crc_clear = (state == ST_IDLE) && cfg_start && !cfg_abort;

    fir_coef_crc16 #(
        .COEF_WIDTH (COEF_WIDTH)
    ) u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (crc_clear),
        .enable (accept),
        .data   (cfg_data),
        .crc    (crc_value)
    );
`else
    logic unused_cfg_crc;
    assign unused_cfg_crc = ^cfg_crc;
`endif

    assign cfg_ready  = (state == ST_LOAD);
    assign cfg_busy   = (state != ST_IDLE);
    assign mix_window = (mix_cnt != '0);

    // Next-state decode; abort beats every other event outside IDLE and suppresses the beat
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_swap    = 1'b0;
        do_abort   = 1'b0;
        load_fail  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    do_abort   = 1'b1;
                    state_next = ST_IDLE;
                end else if (cfg_valid) begin
                    accept = 1'b1;
                    if (addr == LAST_ADDR) begin
`ifdef FIR_COEF_CRC_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_WAIT_SWAP;
`endif
                    end
                end
            end
`ifdef FIR_COEF_CRC_EN
            ST_CHECK: begin
                if (cfg_abort) begin
                    do_abort   = 1'b1;
                    state_next = ST_IDLE;
                end else if (crc_value == cfg_crc) begin
                    state_next = ST_WAIT_SWAP;
                end else begin
                    load_fail  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`endif
            ST_WAIT_SWAP: begin
                if (cfg_abort) begin
                    do_abort   = 1'b1;
                    state_next = ST_IDLE;
                end else if (!sample_valid || (wait_cnt == WAIT_LAST)) begin
                    do_swap    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Tap index: parked at zero while idle, advances on each accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (state == ST_IDLE) begin
            addr <= '0;
        end else if (accept) begin
            addr <= addr + ADDR_WIDTH'(1);
        end
    end

    // Shadow-bank write port, one cycle behind the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_wr_en   <= 1'b0;
            bank_wr_sel  <= 1'b0;
            bank_wr_addr <= '0;
            bank_wr_data <= '0;
        end else begin
            bank_wr_en <= accept;
            if (accept) begin
                bank_wr_sel  <= ~active_bank;
                bank_wr_addr <= addr;
                bank_wr_data <= cfg_data;
            end
        end
    end

    // Counts cycles spent waiting for a sample-free slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT_SWAP) begin
            wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Bank swap and the single-cycle done/error status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_bank <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            active_bank <= active_bank ^ do_swap;
            cfg_done    <= do_swap;
            cfg_error   <= do_abort | load_fail;
        end
    end

    // Mixed-tap window: reloads on every swap, drains one step per input sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_cnt <= '0;
        end else if (do_swap) begin
            mix_cnt <= LAST_ADDR;
        end else if (sample_valid && (mix_cnt != '0)) begin
            mix_cnt <= mix_cnt - ADDR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Directed testbench for fir_coef_bank_ctrl: full loads, deferred and forced
// swaps, abort, async reset mid-load and the mixed-tap window. The CRC
// scenario is exercised when FIR_COEF_CRC_EN is defined.
module tb_fir_coef_bank_ctrl;

    localparam int N = 211;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_data = 16'h0;
    logic [15:0] cfg_crc = 16'h0;
    logic        cfg_ready;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;
    logic        sample_valid = 1'b0;
    logic        bank_wr_en;
    logic        bank_wr_sel;
    logic [7:0]  bank_wr_addr;
    logic [15:0] bank_wr_data;
    logic        active_bank;
    logic        mix_window;

    int   vectors = 0;
    int   miscompares = 0;
    logic exp_bank = 1'b0;
    logic exp_sel;
    logic seen_done;

    fir_coef_bank_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_abort    (cfg_abort),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_crc      (cfg_crc),
        .cfg_ready    (cfg_ready),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error),
        .sample_valid (sample_valid),
        .bank_wr_en   (bank_wr_en),
        .bank_wr_sel  (bank_wr_sel),
        .bank_wr_addr (bank_wr_addr),
        .bank_wr_data (bank_wr_data),
        .active_bank  (active_bank),
        .mix_window   (mix_window)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

`ifdef FIR_COEF_CRC_EN
    function automatic logic [15:0] crc_model(input int first);
        logic [15:0] c;
        logic [15:0] d;
        logic        fb;
        c = 16'hFFFF;
        for (int b = 0; b < N; b++) begin
            d = 16'(first + b);
            for (int k = 15; k >= 0; k--) begin
                fb = c[15] ^ d[k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction
`endif

    // Starts a load and streams N beats of value first+index, checking every shadow write
    task automatic apply_stimulus(input int first, input logic [15:0] crc_flip);
`ifdef FIR_COEF_CRC_EN
        cfg_crc = crc_model(first) ^ crc_flip;
`else
        cfg_crc = crc_flip;
`endif
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check_output("busy_after_start", 32'(cfg_busy), 1);
        exp_sel = ~exp_bank;
        for (int i = 0; i < N; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 16'(first + i);
            check_output("cfg_ready_in_load", 32'(cfg_ready), 1);
            step();
            check_output("wr_en", 32'(bank_wr_en), 1);
            check_output("wr_addr", 32'(bank_wr_addr), i);
            check_output("wr_data", 32'(bank_wr_data), (first + i) & 32'hFFFF);
            check_output("wr_sel", 32'(bank_wr_sel), 32'(exp_sel));
        end
        cfg_valid = 1'b0;
        check_output("cfg_ready_after_last", 32'(cfg_ready), 0);
`ifdef FIR_COEF_CRC_EN
        step();
`endif
    endtask

    initial begin
        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_active_bank", 32'(active_bank), 0);
        check_output("rst_cfg_ready", 32'(cfg_ready), 0);
        check_output("rst_cfg_busy", 32'(cfg_busy), 0);
        check_output("rst_mix_window", 32'(mix_window), 0);
        check_output("rst_wr_en", 32'(bank_wr_en), 0);
        check_output("rst_done", 32'(cfg_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Full load with no samples: swap on the first WAIT_SWAP cycle
        $display("[TB] full load, idle sample slot");
        apply_stimulus(0, 16'h0000);
        check_output("busy_in_wait", 32'(cfg_busy), 1);
        check_output("no_done_yet", 32'(cfg_done), 0);
        step();
        exp_bank = ~exp_bank;
        check_output("done_pulse", 32'(cfg_done), 1);
        check_output("active_after_swap", 32'(active_bank), 32'(exp_bank));
        check_output("busy_after_swap", 32'(cfg_busy), 0);
        check_output("mix_open", 32'(mix_window), 1);
        step();
        check_output("done_one_cycle", 32'(cfg_done), 0);

        // Mixed-tap window drains over 210 samples
        $display("[TB] mix window drain");
        for (int k = 1; k <= N - 1; k++) begin
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            check_output("mix_drain", 32'(mix_window), (k < N - 1) ? 1 : 0);
        end

        // Deferred swap: samples present for 10 waiting cycles
        $display("[TB] deferred swap");
        apply_stimulus(1000, 16'h0000);
        sample_valid = 1'b1;
        seen_done = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (cfg_done) seen_done = 1'b1;
        end
        check_output("defer_no_done", 32'(seen_done), 0);
        check_output("defer_bank_held", 32'(active_bank), 32'(exp_bank));
        sample_valid = 1'b0;
        step();
        exp_bank = ~exp_bank;
        check_output("defer_done", 32'(cfg_done), 1);
        check_output("defer_active", 32'(active_bank), 32'(exp_bank));

        // Second swap while the window is still open reloads the full count
        $display("[TB] swap mid-window");
        for (int k = 0; k < 50; k++) begin
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
        check_output("mix_partial", 32'(mix_window), 1);
        apply_stimulus(2000, 16'h0000);
        step();
        exp_bank = ~exp_bank;
        check_output("reload_done", 32'(cfg_done), 1);
        check_output("reload_active", 32'(active_bank), 32'(exp_bank));
        for (int k = 0; k < N - 2; k++) begin
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
        check_output("reload_still_open", 32'(mix_window), 1);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check_output("reload_closed", 32'(mix_window), 0);

        // Asynchronous reset in the middle of a load
        $display("[TB] reset mid-load");
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 16'(500 + i);
            step();
        end
        check_output("pre_reset_active", 32'(active_bank), 1);
        #2;
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check_output("mid_rst_active", 32'(active_bank), 0);
        check_output("mid_rst_ready", 32'(cfg_ready), 0);
        check_output("mid_rst_busy", 32'(cfg_busy), 0);
        check_output("mid_rst_wr_en", 32'(bank_wr_en), 0);
        check_output("mid_rst_wr_addr", 32'(bank_wr_addr), 0);
        check_output("mid_rst_wr_data", 32'(bank_wr_data), 0);
        check_output("mid_rst_wr_sel", 32'(bank_wr_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_bank = 1'b0;
        step();
        check_output("post_rst_busy", 32'(cfg_busy), 0);

        // Forced swap: samples never stop
        $display("[TB] forced swap on timeout");
        apply_stimulus(3000, 16'h0000);
        sample_valid = 1'b1;
        seen_done = 1'b0;
        for (int j = 0; j < 1023; j++) begin
            step();
            if (cfg_done) seen_done = 1'b1;
        end
        check_output("timeout_no_early_done", 32'(seen_done), 0);
        check_output("timeout_busy", 32'(cfg_busy), 1);
        step();
        exp_bank = ~exp_bank;
        check_output("timeout_done", 32'(cfg_done), 1);
        check_output("timeout_active", 32'(active_bank), 32'(exp_bank));
        sample_valid = 1'b0;
        step();

        // Abort on beat 100
        $display("[TB] abort during load");
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 16'(7000 + i);
            step();
        end
        check_output("abort_prev_addr", 32'(bank_wr_addr), 99);
        cfg_data  = 16'(7100);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        check_output("abort_no_write", 32'(bank_wr_en), 0);
        check_output("abort_error", 32'(cfg_error), 1);
        check_output("abort_busy", 32'(cfg_busy), 0);
        check_output("abort_active", 32'(active_bank), 32'(exp_bank));
        check_output("abort_no_done", 32'(cfg_done), 0);
        step();
        check_output("abort_error_one_cycle", 32'(cfg_error), 0);

        // Abort wins over start in IDLE and raises no error there
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        check_output("idle_abort_no_start", 32'(cfg_busy), 0);
        check_output("idle_abort_no_error", 32'(cfg_error), 0);

`ifdef FIR_COEF_CRC_EN
        // CRC mismatch rejects the set, correct CRC lets it swap
        $display("[TB] crc check");
        apply_stimulus(4000, 16'h0001);
        check_output("crc_bad_error", 32'(cfg_error), 1);
        check_output("crc_bad_idle", 32'(cfg_busy), 0);
        check_output("crc_bad_active", 32'(active_bank), 32'(exp_bank));
        step();
        apply_stimulus(4000, 16'h0000);
        check_output("crc_good_no_error", 32'(cfg_error), 0);
        step();
        exp_bank = ~exp_bank;
        check_output("crc_good_done", 32'(cfg_done), 1);
        check_output("crc_good_active", 32'(active_bank), 32'(exp_bank));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
